usb_ep_buffer_responder: RTL and testbench
==========================================

Name: usb_ep_buffer_responder

Overview:
Device-side endpoint buffer that answers the bridge's out/in endpoint interface (req/grant, data_avail/get, data_free/put/done, acked, stall). It holds one host-OUT packet and one host-IN packet. It connects between the USB packet engine (byte streams with commit/ack) and the uart bridge endpoint. Each direction has its own independent state machine; the two share no arbitration.

Parameters:
OUT_DEPTH, 64, host-OUT packet buffer bytes (power of 2, max packet size)
IN_DEPTH, 64, host-IN packet buffer bytes (power of 2, max packet size)
FLUSH_CYCLES, 4096, idle cycles before auto-close of a partial IN packet (optional feature only)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
out_ep_req / out_ep_grant  in / out  1 / 1  out-endpoint interface request / grant
out_ep_data_avail  out  1  unread OUT bytes present
out_ep_data_get  in  1  pop one OUT byte
out_ep_data  out  8  popped byte, valid the cycle after get
out_ep_setup  out  1  tied 0
out_ep_stall  in  1  consumer requests STALL on host OUT
out_ep_acked  out  1  pulse: OUT packet accepted from host
in_ep_req / in_ep_grant  in / out  1 / 1  in-endpoint interface request / grant
in_ep_data_free  out  1  space for a put
in_ep_data_put  in  1  push in_ep_data
in_ep_data  in  8  byte to host
in_ep_data_done  in  1  close current IN packet
in_ep_stall  in  1  producer requests STALL on host IN
in_ep_acked  out  1  pulse: host ACKed IN packet
rx_data / rx_valid  in  8 / 1  OUT packet bytes from engine
rx_commit / rx_abort  in  1 / 1  packet good (CRC ok) / bad
rx_ready  out  1  buffer empty; engine ACKs, else NAKs
rx_stall / tx_stall  out  1 / 1  registered copies of out_ep_stall / in_ep_stall
tx_pkt_valid  out  1  IN packet ready for host
tx_get  in  1  pop one IN byte
tx_data / tx_last  out  8 / 1  byte and last flag, valid the cycle after tx_get
tx_ack / tx_retry  in  1 / 1  host ACK / timeout (resend)

Behaviour:
Reset values:
- All outputs 0 except rx_ready=1 and in_ep_data_free=0.
- OUT state OUT_EMPTY; IN state IN_FILL; all pointers and counters 0.

Grants:
- out_ep_grant and in_ep_grant are registered copies of the matching req: asserted 1 cycle after req rises, dropped 1 cycle after req falls.

OUT FSM (OUT_EMPTY, OUT_RX, OUT_READY):
- EMPTY: rx_valid writes mem[wptr], wptr++, -> RX.
- RX: further rx_valid writes continue.
- A write with wptr==OUT_DEPTH sets ovf; the byte is dropped.
- rx_commit with ovf==0: cnt<=wptr, pulse out_ep_acked 1 cycle, -> READY; a zero-length commit returns to EMPTY (acked still pulses).
- rx_abort, or rx_commit with ovf==1: clear wptr and ovf, -> EMPTY, no ack.
- rx_ready=1 only in EMPTY or RX. rx_valid while READY is ignored.
- READY: out_ep_data_avail = (rptr!=cnt).
- get && grant && avail: out_ep_data<=mem[rptr], rptr++.
- A get without grant or without avail is ignored; out_ep_data holds its value.
- The cycle rptr reaches cnt: -> EMPTY, rptr and wptr cleared.
- out_ep_stall=1: rx_stall=1; rx_valid and rx_commit are ignored and the buffer contents are kept.

IN FSM (IN_FILL, IN_READY, IN_SEND):
- FILL: in_ep_data_free = grant && cnt<IN_DEPTH.
- put && free: mem[cnt]<=in_ep_data, cnt++. A put while not free is ignored.
- done with cnt>0, or cnt reaching IN_DEPTH: -> READY.
- put and done in the same cycle: the byte is written first, then the packet closes.
- done with cnt==0 is ignored.
- READY/SEND: tx_pkt_valid=1 and in_ep_data_free=0.
- tx_get: tx_data<=mem[rptr], tx_last<=(rptr==cnt-1), rptr++, state SEND.
- tx_ack: cnt and rptr cleared, pulse in_ep_acked, -> FILL.
- tx_retry: rptr<=0, -> READY; data is kept.
- tx_ack and tx_retry together: ack wins.
- tx_get beyond cnt returns the last byte with tx_last=1.
- in_ep_stall drives tx_stall; tx_pkt_valid is forced 0 while stalled.

Async reset mid-packet: both buffers are discarded.

Optional Feature:
USB_EP_IN_FLUSH_EN:
- Defined: a FLUSH_CYCLES counter runs in FILL while cnt>0. It clears on every accepted put. At terminal count the packet auto-closes (-> READY) exactly as done.
- Undefined: there is no counter, and an IN packet closes only on done or when full.

Decomposition:
- Package usb_ep_pkg: OUT and IN state encodings, default max-packet constant, pointer-width function (clog2 of depth + 1).
- Sub-module usb_ep_pkt_ram: single-clock RAM with synchronous write and registered read. Instantiated once per direction.

Test Plan:
- 3-byte OUT (0x41,0x42,0x43) committed, then 3 gets under grant -> out_ep_acked one pulse; out_ep_data 0x41,0x42,0x43 each 1 cycle after its get; avail falls after the 3rd get; rx_ready returns to 1.
- 65 rx bytes with OUT_DEPTH=64, then commit -> no acked, state EMPTY, rx_ready=1; a second rx_valid during READY is ignored.
- Puts 0x10,0x11 then done -> tx_pkt_valid=1; two tx_gets give 0x10 (tx_last=0) then 0x11 (tx_last=1); tx_retry then regets give 0x10 again; tx_ack -> in_ep_acked pulse, free=1.
- 64 puts with no done -> auto-close at cnt=64, free=0 on the following cycle; a 65th put is ignored.
- in_ep_stall=1 with a ready packet -> tx_stall=1, tx_pkt_valid=0; release -> tx_pkt_valid=1 with data intact.
- USB_EP_IN_FLUSH_EN defined, FLUSH_CYCLES=16, one put then idle -> tx_pkt_valid rises 16 cycles later. Macro undefined -> tx_pkt_valid stays 0.

Source files
------------

// File: rtl/usb_ep_pkg.sv
// usb_ep_pkg: shared definitions for the USB endpoint buffer responder.
//   out_state_t : host-OUT buffer states (EMPTY, RX, READY)
//   in_state_t  : host-IN buffer states (FILL, READY, SEND)
//   MAX_PKT     : default max-packet size in bytes
//   ptr_w()     : pointer/counter width able to hold 0..depth inclusive
package usb_ep_pkg;

  typedef enum logic [1:0] {
    OUT_EMPTY = 2'd0,
    OUT_RX    = 2'd1,
    OUT_READY = 2'd2
  } out_state_t;

  typedef enum logic [1:0] {
    IN_FILL  = 2'd0,
    IN_READY = 2'd1,
    IN_SEND  = 2'd2
  } in_state_t;

  localparam int MAX_PKT = 64;

  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/usb_ep_pkt_ram.sv
// usb_ep_pkt_ram: single-clock packet RAM, synchronous write, registered read.
// Ports:
//   clk, reset         : clock, async active-high reset (read register only)
//   we, waddr, wdata   : write port
//   re, raddr, rdata   : read port; rdata updates the cycle after re and
//                        holds its value while re is low
module usb_ep_pkt_ram
  import usb_ep_pkg::*;
#(
  parameter int DEPTH = MAX_PKT,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)   rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/usb_ep_buffer_responder.sv
// usb_ep_buffer_responder: one-packet host-OUT buffer and one-packet host-IN
// buffer between the USB packet engine and the uart bridge endpoint.
//
// Optional feature macro: USB_EP_IN_FLUSH_EN (auto-close a partial IN packet
// after FLUSH_CYCLES idle cycles). Default build has no flush counter.
//
// Ports:
//   clk, reset                      : clock, async active-high reset
//   out_ep_req/grant                : bridge OUT interface request / grant
//   out_ep_data_avail/get/data      : bridge pops OUT bytes
//   out_ep_setup                    : always 0
//   out_ep_stall, out_ep_acked      : STALL request / packet-accepted pulse
//   in_ep_req/grant                 : bridge IN interface request / grant
//   in_ep_data_free/put/data/done   : bridge pushes IN bytes, closes packet
//   in_ep_stall, in_ep_acked        : STALL request / host-ACK pulse
//   rx_data/valid/commit/abort      : engine OUT byte stream + verdict
//   rx_ready                        : buffer can take a packet (ACK vs NAK)
//   rx_stall, tx_stall              : registered stall requests to the engine
//   tx_pkt_valid/get/data/last      : engine reads the IN packet
//   tx_ack, tx_retry                : host ACK / timeout
//   out_state_dbg, in_state_dbg     : current FSM states for observation
//
// Handshakes: a byte moves exactly in a cycle where the pop/push strobe
// (out_ep_data_get, in_ep_data_put, tx_get) is high together with its
// qualifier (grant && data_avail, data_free, tx_pkt_valid state); strobes
// seen without the qualifier are dropped, and popped data appears on the
// registered data output in the following cycle.
module usb_ep_buffer_responder
  import usb_ep_pkg::*;
#(
  parameter int OUT_DEPTH    = MAX_PKT,
  parameter int IN_DEPTH     = MAX_PKT,
  parameter int FLUSH_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       out_ep_req,
  output logic       out_ep_grant,
  output logic       out_ep_data_avail,
  input  logic       out_ep_data_get,
  output logic [7:0] out_ep_data,
  output logic       out_ep_setup,
  input  logic       out_ep_stall,
  output logic       out_ep_acked,
  input  logic       in_ep_req,
  output logic       in_ep_grant,
  output logic       in_ep_data_free,
  input  logic       in_ep_data_put,
  input  logic [7:0] in_ep_data,
  input  logic       in_ep_data_done,
  input  logic       in_ep_stall,
  output logic       in_ep_acked,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       rx_commit,
  input  logic       rx_abort,
  output logic       rx_ready,
  output logic       rx_stall,
  output logic       tx_stall,
  output logic       tx_pkt_valid,
  input  logic       tx_get,
  output logic [7:0] tx_data,
  output logic       tx_last,
  input  logic       tx_ack,
  input  logic       tx_retry,
  output logic [1:0] out_state_dbg,
  output logic [1:0] in_state_dbg
);

  localparam int OPW = ptr_w(OUT_DEPTH);
  localparam int OAW = $clog2(OUT_DEPTH);
  localparam int IPW = ptr_w(IN_DEPTH);
  localparam int IAW = $clog2(IN_DEPTH);
  localparam logic [OPW-1:0] OUT_FULL = OPW'(OUT_DEPTH);
  localparam logic [IPW-1:0] IN_FULL  = IPW'(IN_DEPTH);

  // Grants and stalls are plain registered copies of the requests.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_ep_grant <= 1'b0;
      in_ep_grant  <= 1'b0;
      rx_stall     <= 1'b0;
      tx_stall     <= 1'b0;
    end else begin
      out_ep_grant <= out_ep_req;
      in_ep_grant  <= in_ep_req;
      rx_stall     <= out_ep_stall;
      tx_stall     <= in_ep_stall;
    end
  end

  // ---------------- host-OUT direction ----------------
  out_state_t     out_state;
  logic [OPW-1:0] wptr, rptr_o, cnt_o;
  logic           ovf, out_fire, out_wr;

  assign out_ep_setup      = 1'b0;
  assign out_state_dbg     = out_state;
  assign rx_ready          = (out_state != OUT_READY);
  assign out_ep_data_avail = (out_state == OUT_READY) && (rptr_o != cnt_o);
  assign out_fire          = out_ep_data_get && out_ep_grant && out_ep_data_avail;
  // Abort and commit take priority over a byte in the same cycle.
  assign out_wr = (out_state != OUT_READY) && rx_valid && !out_ep_stall &&
                  !rx_abort && !rx_commit && (wptr != OUT_FULL);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_state    <= OUT_EMPTY;
      wptr         <= '0;
      rptr_o       <= '0;
      cnt_o        <= '0;
      ovf          <= 1'b0;
      out_ep_acked <= 1'b0;
    end else begin
      out_ep_acked <= 1'b0;
      case (out_state)
        OUT_EMPTY, OUT_RX: begin
          if (rx_abort || (rx_commit && !out_ep_stall && ovf)) begin
            wptr      <= '0;
            ovf       <= 1'b0;
            out_state <= OUT_EMPTY;
          end else if (rx_commit && !out_ep_stall) begin
            out_ep_acked <= 1'b1;
            cnt_o        <= wptr;
            rptr_o       <= '0;
            out_state    <= (wptr == '0) ? OUT_EMPTY : OUT_READY;
          end else if (rx_valid && !out_ep_stall) begin
            if (wptr == OUT_FULL) ovf  <= 1'b1;
            else                  wptr <= wptr + 1'b1;
            out_state <= OUT_RX;
          end
        end
        OUT_READY: begin
          if (out_fire) begin
            if (rptr_o + 1'b1 == cnt_o) begin
              rptr_o    <= '0;
              wptr      <= '0;
              out_state <= OUT_EMPTY;
            end else begin
              rptr_o <= rptr_o + 1'b1;
            end
          end
        end
        default: out_state <= OUT_EMPTY;
      endcase
    end
  end

  usb_ep_pkt_ram #(.DEPTH(OUT_DEPTH), .AW(OAW)) u_out_ram (
    .clk   (clk),
    .reset (reset),
    .we    (out_wr),
    .waddr (wptr[OAW-1:0]),
    .wdata (rx_data),
    .re    (out_fire),
    .raddr (rptr_o[OAW-1:0]),
    .rdata (out_ep_data)
  );

  // ---------------- host-IN direction ----------------
  in_state_t      in_state;
  logic [IPW-1:0] cnt_i, rptr_i, cnt_i_nxt, in_last_idx;
  logic           in_put, in_close, in_rd, in_past, flush_close;
  logic [IAW-1:0] in_raddr;

  assign in_state_dbg    = in_state;
  assign in_ep_data_free = (in_state == IN_FILL) && in_ep_grant && (cnt_i < IN_FULL);
  assign in_put          = in_ep_data_put && in_ep_data_free;
  assign cnt_i_nxt       = cnt_i + IPW'(in_put);
  // Close decisions use the count after this cycle's put, so put+done lands
  // the byte before the packet closes.
  assign in_close = (in_ep_data_done && (cnt_i_nxt != '0)) || (cnt_i_nxt == IN_FULL) ||
                    (flush_close && (cnt_i != '0));
  assign tx_pkt_valid = (in_state != IN_FILL) && !tx_stall;
  assign in_rd        = (in_state != IN_FILL) && tx_get && !tx_ack && !tx_retry;
  assign in_last_idx  = cnt_i - 1'b1;
  // Reads past the end keep returning the final byte.
  assign in_past      = (rptr_i >= cnt_i);
  assign in_raddr     = in_past ? in_last_idx[IAW-1:0] : rptr_i[IAW-1:0];

`ifdef USB_EP_IN_FLUSH_EN
  localparam int FW = ptr_w(FLUSH_CYCLES);
  localparam logic [FW-1:0] FLUSH_TC = FW'(FLUSH_CYCLES - 1);
  logic [FW-1:0] flush_cnt;

  // Counts idle cycles of a partially filled packet; any accepted put restarts it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                            flush_cnt <= '0;
    else if (in_state != IN_FILL || cnt_i == '0 || in_put) flush_cnt <= '0;
    else                                                  flush_cnt <= flush_cnt + 1'b1;
  end

  assign flush_close = (in_state == IN_FILL) && !in_put && (flush_cnt == FLUSH_TC);
`else
  // Idle flush is compiled out; this folds to 0 for any legal FLUSH_CYCLES.
  assign flush_close = (FLUSH_CYCLES < 0);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_state    <= IN_FILL;
      cnt_i       <= '0;
      rptr_i      <= '0;
      tx_last     <= 1'b0;
      in_ep_acked <= 1'b0;
    end else begin
      in_ep_acked <= 1'b0;
      case (in_state)
        IN_FILL: begin
          cnt_i <= cnt_i_nxt;
          if (in_close) begin
            rptr_i   <= '0;
            in_state <= IN_READY;
          end
        end
        IN_READY, IN_SEND: begin
          if (tx_ack) begin
            cnt_i       <= '0;
            rptr_i      <= '0;
            in_ep_acked <= 1'b1;
            in_state    <= IN_FILL;
          end else if (tx_retry) begin
            rptr_i   <= '0;
            in_state <= IN_READY;
          end else if (tx_get) begin
            tx_last  <= (rptr_i >= in_last_idx);
            if (!in_past) rptr_i <= rptr_i + 1'b1;
            in_state <= IN_SEND;
          end
        end
        default: in_state <= IN_FILL;
      endcase
    end
  end

  usb_ep_pkt_ram #(.DEPTH(IN_DEPTH), .AW(IAW)) u_in_ram (
    .clk   (clk),
    .reset (reset),
    .we    (in_put),
    .waddr (cnt_i[IAW-1:0]),
    .wdata (in_ep_data),
    .re    (in_rd),
    .raddr (in_raddr),
    .rdata (tx_data)
  );

endmodule

// File: tb/tb_usb_ep_buffer_responder.sv
// tb_usb_ep_buffer_responder: self-checking bench for usb_ep_buffer_responder.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_usb_ep_buffer_responder;
  import usb_ep_pkg::*;

  localparam int OUT_DEPTH    = 64;
  localparam int IN_DEPTH     = 64;
  localparam int FLUSH_CYCLES = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       out_ep_req = 0, out_ep_data_get = 0, out_ep_stall = 0;
  logic       in_ep_req = 0, in_ep_data_put = 0, in_ep_data_done = 0, in_ep_stall = 0;
  logic [7:0] in_ep_data = 0, rx_data = 0;
  logic       rx_valid = 0, rx_commit = 0, rx_abort = 0;
  logic       tx_get = 0, tx_ack = 0, tx_retry = 0;
  logic       out_ep_grant, out_ep_data_avail, out_ep_setup, out_ep_acked;
  logic       in_ep_grant, in_ep_data_free, in_ep_acked;
  logic       rx_ready, rx_stall, tx_stall, tx_pkt_valid, tx_last;
  logic [7:0] out_ep_data, tx_data;
  logic [1:0] out_state_dbg, in_state_dbg;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];
  logic [7:0] pkt[$];
  logic [7:0] last_out = 8'h00;

  always #5 clk = ~clk;

  usb_ep_buffer_responder #(
    .OUT_DEPTH(OUT_DEPTH), .IN_DEPTH(IN_DEPTH), .FLUSH_CYCLES(FLUSH_CYCLES)
  ) dut (
    .clk(clk), .reset(reset),
    .out_ep_req(out_ep_req), .out_ep_grant(out_ep_grant),
    .out_ep_data_avail(out_ep_data_avail), .out_ep_data_get(out_ep_data_get),
    .out_ep_data(out_ep_data), .out_ep_setup(out_ep_setup),
    .out_ep_stall(out_ep_stall), .out_ep_acked(out_ep_acked),
    .in_ep_req(in_ep_req), .in_ep_grant(in_ep_grant),
    .in_ep_data_free(in_ep_data_free), .in_ep_data_put(in_ep_data_put),
    .in_ep_data(in_ep_data), .in_ep_data_done(in_ep_data_done),
    .in_ep_stall(in_ep_stall), .in_ep_acked(in_ep_acked),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_commit(rx_commit), .rx_abort(rx_abort),
    .rx_ready(rx_ready), .rx_stall(rx_stall), .tx_stall(tx_stall),
    .tx_pkt_valid(tx_pkt_valid), .tx_get(tx_get), .tx_data(tx_data), .tx_last(tx_last),
    .tx_ack(tx_ack), .tx_retry(tx_retry),
    .out_state_dbg(out_state_dbg), .in_state_dbg(in_state_dbg)
  );

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rx_byte(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1; tick(); rx_valid = 1'b0;
  endtask

  task automatic pulse_commit();
    rx_commit = 1'b1; tick(); rx_commit = 1'b0;
  endtask

  task automatic out_get();
    out_ep_data_get = 1'b1; tick(); out_ep_data_get = 1'b0;
  endtask

  task automatic in_put(input logic [7:0] b, input logic d);
    in_ep_data = b; in_ep_data_put = 1'b1; in_ep_data_done = d; tick();
    in_ep_data_put = 1'b0; in_ep_data_done = 1'b0;
  endtask

  task automatic in_done();
    in_ep_data_done = 1'b1; tick(); in_ep_data_done = 1'b0;
  endtask

  task automatic tx_pop();
    tx_get = 1'b1; tick(); tx_get = 1'b0;
  endtask

  task automatic host_ack();
    tx_ack = 1'b1; tick(); tx_ack = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (2) tick();
    checks++;
    if ({rx_ready, in_ep_data_free, out_ep_grant, in_ep_grant, out_ep_data_avail, out_ep_acked,
         in_ep_acked, rx_stall, tx_stall, tx_pkt_valid, tx_last, out_ep_setup} !== 12'h800) begin
      errors++; $display("FAIL reset_flags got=%b exp=%b", {rx_ready, in_ep_data_free, out_ep_grant,
        in_ep_grant, out_ep_data_avail, out_ep_acked, in_ep_acked, rx_stall, tx_stall, tx_pkt_valid,
        tx_last, out_ep_setup}, 12'h800);
    end
    checks++;
    if ({out_ep_data, tx_data} !== 16'h0000) begin
      errors++; $display("FAIL reset_data got=%h exp=0000", {out_ep_data, tx_data});
    end
    checks++;
    if (out_state_dbg !== OUT_EMPTY || in_state_dbg !== IN_FILL) begin
      errors++; $display("FAIL reset_states got=%0d/%0d exp=%0d/%0d", out_state_dbg, in_state_dbg,
        OUT_EMPTY, IN_FILL);
    end
    reset = 1'b0;
    out_ep_req = 1'b1; in_ep_req = 1'b1;
    tick();
    checks++;
    if ({out_ep_grant, in_ep_grant, in_ep_data_free} !== 3'b111) begin
      errors++; $display("FAIL grant_rise got=%b exp=111", {out_ep_grant, in_ep_grant, in_ep_data_free});
    end
  endtask

  task automatic test_grants();
    out_ep_req = 1'b0;
    #1;
    checks++;
    if (out_ep_grant !== 1'b1) begin
      errors++; $display("FAIL grant_registered got=%b exp=1", out_ep_grant);
    end
    tick();
    checks++;
    if ({out_ep_grant, in_ep_grant} !== 2'b01) begin
      errors++; $display("FAIL grant_fall got=%b exp=01", {out_ep_grant, in_ep_grant});
    end
    out_ep_req = 1'b1;
    tick();
  endtask

  task automatic test_out_basic();
    rx_byte(8'h41); rx_byte(8'h42); rx_byte(8'h43);
    pulse_commit();
    checks++;
    if ({out_ep_acked, out_ep_data_avail, rx_ready} !== 3'b110) begin
      errors++; $display("FAIL out_commit got=%b exp=110", {out_ep_acked, out_ep_data_avail, rx_ready});
    end
    tick();
    checks++;
    if (out_ep_acked !== 1'b0) begin
      errors++; $display("FAIL out_acked_pulse got=%b exp=0", out_ep_acked);
    end
    exp_q.push_back(8'h41); exp_q.push_back(8'h42); exp_q.push_back(8'h43);
    for (int i = 0; i < 3; i++) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      out_get();
      last_out = e;
      checks++;
      if (out_ep_data !== e) begin
        errors++; $display("FAIL out_basic_data[%0d] got=%h exp=%h", i, out_ep_data, e);
      end
      checks++;
      if (out_ep_data_avail !== (i < 2)) begin
        errors++; $display("FAIL out_basic_avail[%0d] got=%b exp=%b", i, out_ep_data_avail, (i < 2));
      end
    end
    checks++;
    if (rx_ready !== 1'b1) begin
      errors++; $display("FAIL out_basic_rx_ready got=%b exp=1", rx_ready);
    end
  endtask

  task automatic test_out_overflow();
    for (int i = 0; i < OUT_DEPTH + 1; i++) rx_byte(8'(i));
    pulse_commit();
    checks++;
    if ({out_ep_acked, rx_ready, out_ep_data_avail} !== 3'b010 || out_state_dbg !== OUT_EMPTY) begin
      errors++; $display("FAIL out_ovf_drop got=%b st=%0d exp=010 st=%0d",
        {out_ep_acked, rx_ready, out_ep_data_avail}, out_state_dbg, OUT_EMPTY);
    end
    rx_byte(8'hA5); rx_byte(8'h5A);
    pulse_commit();
    checks++;
    if (out_ep_acked !== 1'b1) begin
      errors++; $display("FAIL out_ovf_recover_ack got=%b exp=1", out_ep_acked);
    end
    rx_byte(8'hEE);
    pulse_commit();
    checks++;
    if ({out_ep_acked, out_ep_data_avail, rx_ready} !== 3'b010) begin
      errors++; $display("FAIL out_ready_ignores_rx got=%b exp=010",
        {out_ep_acked, out_ep_data_avail, rx_ready});
    end
    exp_q.push_back(8'hA5); exp_q.push_back(8'h5A);
    while (exp_q.size() > 0) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      out_get();
      last_out = e;
      checks++;
      if (out_ep_data !== e) begin
        errors++; $display("FAIL out_ovf_data got=%h exp=%h", out_ep_data, e);
      end
    end
    checks++;
    if ({out_ep_data_avail, rx_ready} !== 2'b01) begin
      errors++; $display("FAIL out_ovf_end got=%b exp=01", {out_ep_data_avail, rx_ready});
    end
  endtask

  task automatic test_out_stall();
    out_ep_stall = 1'b1;
    tick();
    checks++;
    if (rx_stall !== 1'b1) begin
      errors++; $display("FAIL rx_stall_on got=%b exp=1", rx_stall);
    end
    rx_byte(8'h99);
    pulse_commit();
    checks++;
    if ({out_ep_acked, rx_ready, out_ep_data_avail} !== 3'b010) begin
      errors++; $display("FAIL out_stall_ignore got=%b exp=010", {out_ep_acked, rx_ready, out_ep_data_avail});
    end
    out_ep_stall = 1'b0;
    tick();
    checks++;
    if (rx_stall !== 1'b0) begin
      errors++; $display("FAIL rx_stall_off got=%b exp=0", rx_stall);
    end
    rx_byte(8'h31);
    pulse_commit();
    out_get();
    last_out = 8'h31;
    checks++;
    if ({out_ep_data, out_ep_data_avail} !== {8'h31, 1'b0}) begin
      errors++; $display("FAIL out_after_stall got=%h/%b exp=31/0", out_ep_data, out_ep_data_avail);
    end
  endtask

  task automatic test_out_random();
    int  len;
    bit  ab;
    logic exp_ack;
    for (int p = 0; p < 20; p++) begin
      len = $urandom_range(0, OUT_DEPTH + 4);
      ab  = ($urandom_range(0, 7) == 0);
      pkt.delete();
      for (int i = 0; i < len; i++) pkt.push_back(8'($urandom));
      foreach (pkt[i]) begin
        if ($urandom_range(0, 3) == 0) tick();
        rx_byte(pkt[i]);
      end
      if (ab) begin
        rx_abort = 1'b1; tick(); rx_abort = 1'b0;
        exp_ack = 1'b0;
      end else begin
        pulse_commit();
        exp_ack = (len <= OUT_DEPTH);
      end
      checks++;
      if (out_ep_acked !== exp_ack) begin
        errors++; $display("FAIL out_rand_ack[%0d] len=%0d got=%b exp=%b", p, len, out_ep_acked, exp_ack);
      end
      if (exp_ack) foreach (pkt[i]) exp_q.push_back(pkt[i]);
      while (exp_q.size() > 0) begin
        logic [7:0] e;
        if ($urandom_range(0, 3) == 0) begin
          out_ep_req = 1'b0; tick();
          out_get();
          checks++;
          if (out_ep_data !== last_out) begin
            errors++; $display("FAIL out_get_no_grant got=%h exp=%h", out_ep_data, last_out);
          end
          out_ep_req = 1'b1; tick();
        end
        checks++;
        if (out_ep_data_avail !== 1'b1) begin
          errors++; $display("FAIL out_rand_avail got=%b exp=1", out_ep_data_avail);
        end
        e = exp_q.pop_front();
        out_get();
        last_out = e;
        checks++;
        if (out_ep_data !== e) begin
          errors++; $display("FAIL out_rand_data[%0d] got=%h exp=%h", p, out_ep_data, e);
        end
      end
      checks++;
      if ({out_ep_data_avail, rx_ready} !== 2'b01) begin
        errors++; $display("FAIL out_rand_end[%0d] got=%b exp=01", p, {out_ep_data_avail, rx_ready});
      end
    end
  endtask

  task automatic test_in_basic();
    in_done();
    checks++;
    if ({tx_pkt_valid, in_ep_data_free} !== 2'b01) begin
      errors++; $display("FAIL in_done_empty got=%b exp=01", {tx_pkt_valid, in_ep_data_free});
    end
    in_put(8'h10, 1'b0); in_put(8'h11, 1'b0); in_done();
    checks++;
    if ({tx_pkt_valid, in_ep_data_free} !== 2'b10) begin
      errors++; $display("FAIL in_closed got=%b exp=10", {tx_pkt_valid, in_ep_data_free});
    end
    tx_pop();
    checks++;
    if ({tx_data, tx_last} !== {8'h10, 1'b0}) begin
      errors++; $display("FAIL in_get0 got=%h/%b exp=10/0", tx_data, tx_last);
    end
    tx_pop();
    checks++;
    if ({tx_data, tx_last} !== {8'h11, 1'b1}) begin
      errors++; $display("FAIL in_get1 got=%h/%b exp=11/1", tx_data, tx_last);
    end
    tx_retry = 1'b1; tick(); tx_retry = 1'b0;
    tx_pop();
    checks++;
    if ({tx_pkt_valid, tx_data, tx_last} !== {1'b1, 8'h10, 1'b0}) begin
      errors++; $display("FAIL in_retry got=%b/%h/%b exp=1/10/0", tx_pkt_valid, tx_data, tx_last);
    end
    host_ack();
    checks++;
    if ({in_ep_acked, in_ep_data_free, tx_pkt_valid} !== 3'b110) begin
      errors++; $display("FAIL in_ack got=%b exp=110", {in_ep_acked, in_ep_data_free, tx_pkt_valid});
    end
    tick();
    checks++;
    if (in_ep_acked !== 1'b0) begin
      errors++; $display("FAIL in_acked_pulse got=%b exp=0", in_ep_acked);
    end
    in_put(8'h77, 1'b1);
    tx_pop();
    checks++;
    if ({tx_pkt_valid, tx_data, tx_last} !== {1'b1, 8'h77, 1'b1}) begin
      errors++; $display("FAIL in_put_done got=%b/%h/%b exp=1/77/1", tx_pkt_valid, tx_data, tx_last);
    end
    tx_pop();
    checks++;
    if ({tx_data, tx_last} !== {8'h77, 1'b1}) begin
      errors++; $display("FAIL in_get_beyond got=%h/%b exp=77/1", tx_data, tx_last);
    end
    tx_ack = 1'b1; tx_retry = 1'b1; tick(); tx_ack = 1'b0; tx_retry = 1'b0;
    checks++;
    if ({in_ep_acked, tx_pkt_valid, in_ep_data_free} !== 3'b101) begin
      errors++; $display("FAIL in_ack_wins got=%b exp=101", {in_ep_acked, tx_pkt_valid, in_ep_data_free});
    end
  endtask

  task automatic test_in_full();
    logic [7:0] b;
    pkt.delete();
    in_ep_data_put = 1'b1;
    for (int i = 0; i < IN_DEPTH; i++) begin
      b = 8'(i * 3 + 1);
      pkt.push_back(b);
      checks++;
      if (in_ep_data_free !== 1'b1) begin
        errors++; $display("FAIL in_full_free[%0d] got=%b exp=1", i, in_ep_data_free);
      end
      in_ep_data = b;
      tick();
    end
    checks++;
    if ({in_ep_data_free, tx_pkt_valid} !== 2'b01) begin
      errors++; $display("FAIL in_autoclose got=%b exp=01", {in_ep_data_free, tx_pkt_valid});
    end
    in_ep_data = 8'hFF;
    tick();
    in_ep_data_put = 1'b0;
    for (int i = 0; i < IN_DEPTH; i++) begin
      tx_pop();
      checks++;
      if ({tx_data, tx_last} !== {pkt[i], (i == IN_DEPTH - 1)}) begin
        errors++; $display("FAIL in_full_data[%0d] got=%h/%b exp=%h/%b", i, tx_data, tx_last,
          pkt[i], (i == IN_DEPTH - 1));
      end
    end
    tx_pop();
    checks++;
    if ({tx_data, tx_last} !== {pkt[IN_DEPTH-1], 1'b1}) begin
      errors++; $display("FAIL in_65th_ignored got=%h/%b exp=%h/1", tx_data, tx_last, pkt[IN_DEPTH-1]);
    end
    host_ack();
  endtask

  task automatic test_in_stall();
    in_put(8'hC1, 1'b0); in_put(8'hC2, 1'b1);
    in_ep_stall = 1'b1;
    tick();
    checks++;
    if ({tx_stall, tx_pkt_valid} !== 2'b10) begin
      errors++; $display("FAIL in_stall_on got=%b exp=10", {tx_stall, tx_pkt_valid});
    end
    in_ep_stall = 1'b0;
    tick();
    checks++;
    if ({tx_stall, tx_pkt_valid} !== 2'b01) begin
      errors++; $display("FAIL in_stall_off got=%b exp=01", {tx_stall, tx_pkt_valid});
    end
    tx_pop();
    checks++;
    if ({tx_data, tx_last} !== {8'hC1, 1'b0}) begin
      errors++; $display("FAIL in_stall_data0 got=%h/%b exp=c1/0", tx_data, tx_last);
    end
    tx_pop();
    checks++;
    if ({tx_data, tx_last} !== {8'hC2, 1'b1}) begin
      errors++; $display("FAIL in_stall_data1 got=%h/%b exp=c2/1", tx_data, tx_last);
    end
    host_ack();
  endtask

  task automatic test_in_random();
    int len, k;
    bit same;
    for (int p = 0; p < 12; p++) begin
      len  = $urandom_range(1, IN_DEPTH);
      same = $urandom_range(0, 1) == 1;
      pkt.delete();
      for (int i = 0; i < len; i++) pkt.push_back(8'($urandom));
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) tick();
        in_put(pkt[i], same && (i == len - 1));
      end
      if (!same) in_done();
      checks++;
      if (tx_pkt_valid !== 1'b1) begin
        errors++; $display("FAIL in_rand_valid[%0d] got=%b exp=1", p, tx_pkt_valid);
      end
      k = $urandom_range(0, len);
      for (int i = 0; i < k; i++) begin
        tx_pop();
        checks++;
        if ({tx_data, tx_last} !== {pkt[i], (i == len - 1)}) begin
          errors++; $display("FAIL in_rand_pre[%0d.%0d] got=%h/%b exp=%h/%b", p, i, tx_data, tx_last,
            pkt[i], (i == len - 1));
        end
      end
      tx_retry = 1'b1; tick(); tx_retry = 1'b0;
      for (int i = 0; i < len; i++) begin
        tx_pop();
        checks++;
        if ({tx_data, tx_last} !== {pkt[i], (i == len - 1)}) begin
          errors++; $display("FAIL in_rand_data[%0d.%0d] got=%h/%b exp=%h/%b", p, i, tx_data, tx_last,
            pkt[i], (i == len - 1));
        end
      end
      host_ack();
      checks++;
      if (in_ep_acked !== 1'b1) begin
        errors++; $display("FAIL in_rand_ack[%0d] got=%b exp=1", p, in_ep_acked);
      end
    end
  endtask

  task automatic test_flush();
    in_put(8'h5C, 1'b0);
`ifdef USB_EP_IN_FLUSH_EN
    begin
      int n;
      n = 0;
      while (!tx_pkt_valid && n < 4 * FLUSH_CYCLES) begin
        tick(); n++;
      end
      checks++;
      if (n != FLUSH_CYCLES) begin
        errors++; $display("FAIL flush_latency got=%0d exp=%0d", n, FLUSH_CYCLES);
      end
    end
`else
    begin
      bit seen;
      seen = 1'b0;
      repeat (4 * FLUSH_CYCLES) begin
        tick();
        if (tx_pkt_valid) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
        errors++; $display("FAIL no_flush got=%b exp=0", seen);
      end
      in_done();
    end
`endif
    tx_pop();
    checks++;
    if ({tx_pkt_valid, tx_data, tx_last} !== {1'b1, 8'h5C, 1'b1}) begin
      errors++; $display("FAIL flush_data got=%b/%h/%b exp=1/5c/1", tx_pkt_valid, tx_data, tx_last);
    end
    host_ack();
  endtask

  task automatic test_reset_mid();
    rx_byte(8'h11); pulse_commit();
    in_put(8'h22, 1'b1);
    checks++;
    if ({rx_ready, out_ep_data_avail, tx_pkt_valid} !== 3'b011) begin
      errors++; $display("FAIL premid_setup got=%b exp=011", {rx_ready, out_ep_data_avail, tx_pkt_valid});
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({rx_ready, out_ep_data_avail, tx_pkt_valid, in_ep_data_free, out_ep_grant} !== 5'b10000) begin
      errors++; $display("FAIL reset_mid got=%b exp=10000",
        {rx_ready, out_ep_data_avail, tx_pkt_valid, in_ep_data_free, out_ep_grant});
    end
    tick();
    reset = 1'b0;
    tick(); tick();
    checks++;
    if ({rx_ready, out_ep_data_avail, tx_pkt_valid, in_ep_data_free} !== 4'b1001) begin
      errors++; $display("FAIL reset_mid_after got=%b exp=1001",
        {rx_ready, out_ep_data_avail, tx_pkt_valid, in_ep_data_free});
    end
  endtask

  initial begin
    test_reset();
    test_grants();
    test_out_basic();
    test_out_overflow();
    test_out_stall();
    test_out_random();
    test_in_basic();
    test_in_full();
    test_in_stall();
    test_in_random();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
